sccb_config_seq: RTL and testbench
==================================

Name: sccb_config_seq

Overview:
- Parametrised, table-driven successor to the fixed SCCB register-config sequencer.
- Walks an external config ROM and issues OCP-style write/read commands to the SCCB master.
- Supports end-of-table, read-verify and delay opcodes, bounded retry, restart on demand, and done/error status.
- Sits between the camera config ROM and the SCCB master, in the config_clk domain.

Parameters:
- DEV_ID, 7'h21: 7-bit SCCB device ID; drives maddr upper bits.
- REG_AW, 8: register address width.
- REG_DW, 8: register data width.
- ROM_AW, 8: config ROM address width (depth 2**ROM_AW).
- SCCB_DIV, 50: value driven on sccb_div.
- MAX_RETRY, 3: retries per entry after the first attempt (0 = no retry).

Ports:
- config_clk  in  1  sole clock.
- config_reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; (re)runs the table from entry 0 when in IDLE, DONE or ERROR; ignored while busy.
- rom_addr  out  ROM_AW  ROM entry index; ROM returns data one cycle later.
- rom_data  in  2+REG_AW+REG_DW  entry {op[1:0], addr, data}.
- sccb_div  out  8  constant SCCB_DIV.
- mcmd  out  3  0 idle, 1 write, 2 read.
- maddr  out  7+REG_AW  {DEV_ID, reg addr}.
- mdata  out  REG_DW  write data.
- scmdaccept  in  1  master accepted the current mcmd.
- sresp  in  2  00 none, 01 DVA, 10 FAIL, 11 ERR.
- sdata  in  REG_DW  read data, valid with DVA.
- busy  out  1  high outside IDLE/DONE/ERROR.
- done  out  1  level; table finished cleanly.
- error  out  1  level; retries exhausted.
- err_index  out  ROM_AW  entry that failed.

Behaviour:
- Reset values: state=IDLE, rom_addr=0, mcmd=0, maddr={DEV_ID,0}, mdata=0, busy=0, done=0, error=0, err_index=0, retry counter=0. Reset mid-transaction abandons it; mcmd drops to 0 on the next edge.
- Auto-start: the first cycle after reset release behaves as a start pulse.
- FETCH (1 cycle): rom_addr = idx; go to DECODE.
- DECODE, by op:
  - 00 END: go to DONE.
  - 01 WRITE: load maddr/mdata, mcmd=1, go to ISSUE.
  - 10 READ-VERIFY: mcmd=2, go to ISSUE.
  - 11 DELAY: load counter with {addr,data}, go to DELAY.
- ISSUE: hold mcmd/maddr/mdata stable until scmdaccept=1; mcmd=0 the cycle after acceptance.
  - sresp may arrive in the accept cycle (go straight to EVAL) or later (go to WAIT_RESP).
- WAIT_RESP: wait for sresp != 00. No timeout.
- EVAL:
  - DVA on a write → pass.
  - DVA on a read → pass iff sdata == entry data.
  - FAIL, ERR or mismatch → failure.
    - retry < MAX_RETRY: increment retry, go to ISSUE.
    - Otherwise: error=1, err_index=idx, go to ERROR.
- Pass → NEXT: retry=0. If idx is all-ones → DONE (no wrap); else idx+1 → FETCH.
- DELAY:
  - Decrements once per cycle, then NEXT. A count of 0 passes straight to NEXT.
  - Total cycles from DECODE to NEXT = count+1.
- DONE/ERROR: hold outputs until start.
  - start clears done/error/err_index, sets idx=0 and goes to FETCH.
  - start and reset together: reset wins.
- Minimum per-entry overhead is 3 cycles (FETCH, DECODE, NEXT) plus handshake.

Optional Feature:
- CFG_READBACK_EN defined: READ-VERIFY behaves as above.
- Not defined:
  - op 10 is treated as a skip (straight to NEXT, no bus command).
  - sdata is unused.
  - The comparator and read path are removed.

Decomposition:
- Package sccb_cfg_pkg:
  - opcode constants OP_END/OP_WRITE/OP_READ/OP_DELAY.
  - SRESP_NONE/DVA/FAIL/ERR.
  - MCMD_IDLE/WR/RD.
  - state encoding typedef.
- Sub-module sccb_cfg_timer: loadable down-counter with zero flag, width REG_AW+REG_DW, used by DELAY.

Test Plan:
- 3-entry table (WRITE 12/80, WRITE 11/01, END), scmdaccept after 2 cycles, DVA next cycle → maddr=0x2112 then 0x2111, mdata as given, done=1, busy=0, error=0.
- Entry 0 gets FAIL twice then DVA, MAX_RETRY=3 → entry issued 3 times, done=1. Entry 0 gets 4× ERR → error=1, err_index=0, no further mcmd.
- READ-VERIFY addr 0A, expect 76; sdata=76 → pass. sdata=77 ×4 → error=1 (CFG_READBACK_EN). Without the macro → no mcmd for that entry.
- DELAY count 0x0005 between two writes → exactly 6 cycles from DECODE to NEXT, mcmd=0 throughout.
- Table with no END, ROM_AW=2 → 4 writes, then done=1 with rom_addr held at 3. A start pulse then reruns from entry 0.
- config_reset asserted while ISSUE is waiting for scmdaccept → next cycle mcmd=0, all outputs at reset values, sequence restarts from entry 0 after release.

Source files
------------

// File: rtl/sccb_cfg_pkg.sv
// Shared opcodes, SCCB response/command codes and FSM state encoding
// for the table-driven SCCB config sequencer.
package sccb_cfg_pkg;

    localparam logic [1:0] OP_END   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_DELAY = 2'b11;

    localparam logic [1:0] SRESP_NONE = 2'b00;
    localparam logic [1:0] SRESP_DVA  = 2'b01;
    localparam logic [1:0] SRESP_FAIL = 2'b10;
    localparam logic [1:0] SRESP_ERR  = 2'b11;

    localparam logic [2:0] MCMD_IDLE = 3'd0;
    localparam logic [2:0] MCMD_WR   = 3'd1;
    localparam logic [2:0] MCMD_RD   = 3'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_RESP,
        ST_EVAL,
        ST_NEXT,
        ST_DELAY,
        ST_DONE,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/sccb_cfg_timer.sv
// Loadable down-counter with zero flag; paces DELAY table entries.
module sccb_cfg_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sccb_config_seq.sv
// Table-driven SCCB register-config sequencer (config ROM -> SCCB master).
// Define CFG_READBACK_EN to enable read-verify entries; otherwise op 10 is a skip.
module sccb_config_seq
    import sccb_cfg_pkg::*;
#(
    parameter logic [6:0] DEV_ID    = 7'h21,
    parameter int         REG_AW    = 8,
    parameter int         REG_DW    = 8,
    parameter int         ROM_AW    = 8,
    parameter int         SCCB_DIV  = 50,
    parameter int         MAX_RETRY = 3
) (
    input  logic                     config_clk,
    input  logic                     config_reset,
    input  logic                     start,
    output logic [ROM_AW-1:0]        rom_addr,
    input  logic [2+REG_AW+REG_DW-1:0] rom_data,
    output logic [7:0]               sccb_div,
    output logic [2:0]               mcmd,
    output logic [7+REG_AW-1:0]      maddr,
    output logic [REG_DW-1:0]        mdata,
    input  logic                     scmdaccept,
    input  logic [1:0]               sresp,
    input  logic [REG_DW-1:0]        sdata,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ROM_AW-1:0]        err_index
);

    localparam int CW = REG_AW + REG_DW;
    localparam int EW = 2 + CW;
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_e              state_q;
    logic [ROM_AW-1:0]   idx_q;
    logic [2:0]          mcmd_q;
    logic [7+REG_AW-1:0] maddr_q;
    logic [REG_DW-1:0]   mdata_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic [ROM_AW-1:0]   err_idx_q;
    logic [RW-1:0]       retry_q;
    logic                auto_q;
    logic [1:0]          resp_q;
`ifdef CFG_READBACK_EN
    logic                is_rd_q;
    logic [REG_DW-1:0]   exp_q;
    logic [REG_DW-1:0]   rdata_q;
`else
    logic                unused_sdata;
    assign unused_sdata = ^sdata;
`endif

    logic [1:0]        ent_op;
    logic [REG_AW-1:0] ent_addr;
    logic [REG_DW-1:0] ent_data;
    logic [CW-1:0]     ent_cnt;

    assign ent_op   = rom_data[EW-1 -: 2];
    assign ent_addr = rom_data[CW-1 -: REG_AW];
    assign ent_data = rom_data[REG_DW-1:0];
    assign ent_cnt  = rom_data[CW-1:0];

    // Timer holds count-1 so DELAY spends exactly count cycles before NEXT
    logic          tmr_load;
    logic          tmr_dec;
    logic          tmr_zero;
    logic [CW-1:0] tmr_val;

    assign tmr_load = (state_q == ST_DECODE) && (ent_op == OP_DELAY);
    assign tmr_dec  = (state_q == ST_DELAY);
    assign tmr_val  = ent_cnt - 1'b1;

    sccb_cfg_timer #(
        .W(CW)
    ) u_timer (
        .clk_i (config_clk),
        .rst_i (config_reset),
        .load_i(tmr_load),
        .val_i (tmr_val),
        .dec_i (tmr_dec),
        .zero_o(tmr_zero)
    );

    logic       eval_pass;
    logic       retry_ok;
    logic [2:0] reissue_cmd;

    always_comb begin
        eval_pass   = (resp_q == SRESP_DVA);
        reissue_cmd = MCMD_WR;
`ifdef CFG_READBACK_EN
        if (is_rd_q && rdata_q != exp_q) eval_pass = 1'b0;
        if (is_rd_q) reissue_cmd = MCMD_RD;
`endif
    end

    assign retry_ok = (int'(retry_q) < MAX_RETRY);

    always_ff @(posedge config_clk) begin
        if (config_reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            mcmd_q    <= MCMD_IDLE;
            maddr_q   <= {DEV_ID, {REG_AW{1'b0}}};
            mdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
            retry_q   <= '0;
            auto_q    <= 1'b1;
            resp_q    <= SRESP_NONE;
`ifdef CFG_READBACK_EN
            is_rd_q   <= 1'b0;
            exp_q     <= '0;
            rdata_q   <= '0;
`endif
        end else begin
            auto_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start || auto_q) begin
                        idx_q     <= '0;
                        done_q    <= 1'b0;
                        error_q   <= 1'b0;
                        err_idx_q <= '0;
                        retry_q   <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_FETCH;
                    end
                end
                ST_FETCH: state_q <= ST_DECODE;
                ST_DECODE: begin
                    unique case (ent_op)
                        OP_END: begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                        OP_WRITE: begin
                            maddr_q <= {DEV_ID, ent_addr};
                            mdata_q <= ent_data;
                            mcmd_q  <= MCMD_WR;
`ifdef CFG_READBACK_EN
                            is_rd_q <= 1'b0;
`endif
                            state_q <= ST_ISSUE;
                        end
                        OP_READ: begin
`ifdef CFG_READBACK_EN
                            maddr_q <= {DEV_ID, ent_addr};
                            exp_q   <= ent_data;
                            is_rd_q <= 1'b1;
                            mcmd_q  <= MCMD_RD;
                            state_q <= ST_ISSUE;
`else
                            state_q <= ST_NEXT;
`endif
                        end
                        OP_DELAY: begin
                            state_q <= (ent_cnt == '0) ? ST_NEXT : ST_DELAY;
                        end
                    endcase
                end
                ST_ISSUE: begin
                    if (scmdaccept) begin
                        mcmd_q <= MCMD_IDLE;
                        if (sresp != SRESP_NONE) begin
                            resp_q  <= sresp;
`ifdef CFG_READBACK_EN
                            rdata_q <= sdata;
`endif
                            state_q <= ST_EVAL;
                        end else begin
                            state_q <= ST_WAIT_RESP;
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (sresp != SRESP_NONE) begin
                        resp_q  <= sresp;
`ifdef CFG_READBACK_EN
                        rdata_q <= sdata;
`endif
                        state_q <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (eval_pass) begin
                        state_q <= ST_NEXT;
                    end else if (retry_ok) begin
                        retry_q <= retry_q + 1'b1;
                        mcmd_q  <= reissue_cmd;
                        state_q <= ST_ISSUE;
                    end else begin
                        error_q   <= 1'b1;
                        err_idx_q <= idx_q;
                        busy_q    <= 1'b0;
                        state_q   <= ST_ERROR;
                    end
                end
                ST_NEXT: begin
                    retry_q <= '0;
                    // Last ROM slot finishes the table rather than wrapping
                    if (&idx_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_DELAY: begin
                    if (tmr_zero) state_q <= ST_NEXT;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rom_addr  = idx_q;
    assign sccb_div  = 8'(SCCB_DIV);
    assign mcmd      = mcmd_q;
    assign maddr     = maddr_q;
    assign mdata     = mdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_index = err_idx_q;

endmodule

// File: tb/tb_sccb_config_seq.sv
// Directed self-checking bench for sccb_config_seq (ROM_AW=2, 4-entry ROM),
// with a reactive SCCB master model and command log.
module tb_sccb_config_seq;

    localparam int AW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [17:0] rom_data;
    logic [7:0]  sccb_div;
    logic [2:0]  mcmd;
    logic [14:0] maddr;
    logic [7:0]  mdata;
    logic        scmdaccept = 1'b0;
    logic [1:0]  sresp = 2'b00;
    logic [7:0]  sdata = 8'h00;
    logic        busy;
    logic        done;
    logic        error;
    logic [AW-1:0] err_index;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    sccb_config_seq #(
        .DEV_ID   (7'h21),
        .REG_AW   (8),
        .REG_DW   (8),
        .ROM_AW   (AW),
        .SCCB_DIV (50),
        .MAX_RETRY(3)
    ) dut (
        .config_clk  (clk),
        .config_reset(rst),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sccb_div    (sccb_div),
        .mcmd        (mcmd),
        .maddr       (maddr),
        .mdata       (mdata),
        .scmdaccept  (scmdaccept),
        .sresp       (sresp),
        .sdata       (sdata),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_index   (err_index)
    );

    // Synchronous config ROM: data one cycle after address
    logic [17:0] rom [4];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // SCCB master model: accept after acc_dly waiting cycles, respond next cycle
    int          acc_dly = 2;
    int          wcnt = 0;
    bit          pend = 1'b0;
    logic [9:0]  cur = 10'h0;
    logic [9:0]  rq[$];
    logic [25:0] log_q[$];
    int          gap = 0;
    int          gaps[$];

    always @(negedge clk) begin
        scmdaccept = 1'b0;
        sresp = 2'b00;
        if (pend) begin
            sresp = cur[9:8];
            sdata = cur[7:0];
            pend = 1'b0;
            wcnt = 0;
        end else if (mcmd != 3'd0) begin
            if (wcnt >= acc_dly) begin
                scmdaccept = 1'b1;
                log_q.push_back({mcmd, maddr, mdata});
                cur = (rq.size() > 0) ? rq.pop_front() : 10'h100;
                pend = 1'b1;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
        if (mcmd == 3'd0) begin
            gap++;
        end else if (gap > 0) begin
            gaps.push_back(gap);
            gap = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] ent(input logic [1:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] d);
        return {op, a, d};
    endfunction

    function automatic logic [25:0] expw(input logic [7:0] a,
                                         input logic [7:0] d);
        return {3'd1, 7'h21, a, d};
    endfunction

    function automatic logic [25:0] logat(input int i);
        if (i < log_q.size()) return log_q[i];
        return '1;
    endfunction

    function automatic int gapat(input int i);
        if (i < gaps.size()) return gaps[i];
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rq.delete();
        log_q.delete();
        gaps.delete();
        gap = 0;
        pend = 1'b0;
        wcnt = 0;
        acc_dly = 2;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_end(input int n);
        int k = 0;
        while (!(done || error) && k < n) begin
            @(negedge clk);
            k++;
        end
        chk("end_reached", 32'(done || error), 32'd1);
    endtask

    task automatic wait_cmd(input int n);
        int k = 0;
        while (mcmd == 3'd0 && k < n) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_seen", 32'(mcmd != 3'd0), 32'd1);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_mcmd", 32'(mcmd), 32'd0);
        chk("rst_maddr", 32'(maddr), 32'h2100);
        chk("rst_mdata", 32'(mdata), 32'd0);
        chk("rst_romaddr", 32'(rom_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_erridx", 32'(err_index), 32'd0);
        chk("sccb_div", 32'(sccb_div), 32'd50);

        // Two writes then END
        rom[0] = ent(2'b01, 8'h12, 8'h80);
        rom[1] = ent(2'b01, 8'h11, 8'h01);
        rom[2] = ent(2'b00, 8'h00, 8'h00);
        rom[3] = ent(2'b00, 8'h00, 8'h00);
        release_rst();
        wait_cmd(50);
        chk("t1_busy_run", 32'(busy), 32'd1);
        chk("t1_maddr_run", 32'(maddr), 32'h2112);
        wait_end(300);
        chk("t1_nlog", 32'(log_q.size()), 32'd2);
        chk("t1_cmd0", 32'(logat(0)), 32'(expw(8'h12, 8'h80)));
        chk("t1_cmd1", 32'(logat(1)), 32'(expw(8'h11, 8'h01)));
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_error", 32'(error), 32'd0);
        chk("t1_gap", 32'(gapat(1)), 32'd5);

        // FAIL, FAIL, then DVA: entry issued three times
        do_reset();
        rom[0] = ent(2'b01, 8'h12, 8'h80);
        rom[1] = ent(2'b00, 8'h00, 8'h00);
        rq.push_back(10'h200);
        rq.push_back(10'h200);
        rq.push_back(10'h100);
        release_rst();
        wait_end(300);
        chk("t2_nlog", 32'(log_q.size()), 32'd3);
        chk("t2_cmd2", 32'(logat(2)), 32'(expw(8'h12, 8'h80)));
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_error", 32'(error), 32'd0);

        // Four ERR responses exhaust retries
        do_reset();
        repeat (4) rq.push_back(10'h300);
        release_rst();
        wait_end(300);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_erridx", 32'(err_index), 32'd0);
        chk("t3_done", 32'(done), 32'd0);
        chk("t3_nlog", 32'(log_q.size()), 32'd4);
        repeat (20) @(negedge clk);
        chk("t3_nlog_hold", 32'(log_q.size()), 32'd4);
        chk("t3_mcmd_idle", 32'(mcmd), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);

        // Read-verify with matching data
        do_reset();
        rom[0] = ent(2'b01, 8'h12, 8'h80);
        rom[1] = ent(2'b10, 8'h0A, 8'h76);
        rom[2] = ent(2'b00, 8'h00, 8'h00);
        rq.push_back(10'h100);
        rq.push_back(10'h176);
        release_rst();
        wait_end(300);
        chk("t4_done", 32'(done), 32'd1);
`ifdef CFG_READBACK_EN
        chk("t4_nlog", 32'(log_q.size()), 32'd2);
        chk("t4_rdcmd", 32'(logat(1) >> 8), 32'h2210A);
`else
        chk("t4_nlog", 32'(log_q.size()), 32'd1);
`endif

        // Read-verify with mismatching data on entry 1
        do_reset();
        rq.push_back(10'h100);
        repeat (4) rq.push_back(10'h177);
        release_rst();
        wait_end(300);
`ifdef CFG_READBACK_EN
        chk("t5_error", 32'(error), 32'd1);
        chk("t5_erridx", 32'(err_index), 32'd1);
        chk("t5_nlog", 32'(log_q.size()), 32'd5);
`else
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_error", 32'(error), 32'd0);
        chk("t5_nlog", 32'(log_q.size()), 32'd1);
`endif

        // DELAY of 5 between two writes: idle gap 5 + 8
        do_reset();
        rom[0] = ent(2'b01, 8'h12, 8'h80);
        rom[1] = ent(2'b11, 8'h00, 8'h05);
        rom[2] = ent(2'b01, 8'h11, 8'h01);
        rom[3] = ent(2'b00, 8'h00, 8'h00);
        release_rst();
        wait_end(300);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_nlog", 32'(log_q.size()), 32'd2);
        chk("t6_cmd1", 32'(logat(1)), 32'(expw(8'h11, 8'h01)));
        chk("t6_gap", 32'(gapat(1)), 32'd13);

        // No END: four writes, stop at last slot, then rerun on start
        do_reset();
        rom[0] = ent(2'b01, 8'h10, 8'hA0);
        rom[1] = ent(2'b01, 8'h11, 8'hA1);
        rom[2] = ent(2'b01, 8'h12, 8'hA2);
        rom[3] = ent(2'b01, 8'h13, 8'hA3);
        release_rst();
        wait_end(400);
        chk("t7_done", 32'(done), 32'd1);
        chk("t7_romaddr", 32'(rom_addr), 32'd3);
        chk("t7_nlog", 32'(log_q.size()), 32'd4);
        chk("t7_cmd3", 32'(logat(3)), 32'(expw(8'h13, 8'hA3)));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t7_done_clr", 32'(done), 32'd0);
        chk("t7_busy_rerun", 32'(busy), 32'd1);
        wait_end(400);
        chk("t7_nlog_rerun", 32'(log_q.size()), 32'd8);
        chk("t7_cmd4", 32'(logat(4)), 32'(expw(8'h10, 8'hA0)));
        chk("t7_done_rerun", 32'(done), 32'd1);

        // Reset while entry 2 waits for accept
        do_reset();
        release_rst();
        begin
            int k = 0;
            while (log_q.size() < 2 && k < 200) begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        chk("t8_two_acc", 32'(log_q.size()), 32'd2);
        acc_dly = 1000;
        wait_cmd(50);
        chk("t8_romaddr_run", 32'(rom_addr), 32'd2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t8_mcmd", 32'(mcmd), 32'd0);
        chk("t8_busy", 32'(busy), 32'd0);
        chk("t8_maddr", 32'(maddr), 32'h2100);
        chk("t8_mdata", 32'(mdata), 32'd0);
        chk("t8_romaddr", 32'(rom_addr), 32'd0);
        acc_dly = 2;
        release_rst();
        wait_end(400);
        chk("t8_nlog", 32'(log_q.size()), 32'd6);
        chk("t8_restart", 32'(logat(2)), 32'(expw(8'h10, 8'hA0)));
        chk("t8_done", 32'(done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
